// File: rtl/trdb_packet_arbiter_if.sv
// Packet bus between the per-source packet FIFOs, the arbiter and the trace stream aligner.
// master: arbiter side. slave: sources/aligner side.
interface trdb_packet_arbiter_if #(
    parameter int N_REQ             = 3,
    parameter int PACKET_LEN        = 32,
    parameter int PACKET_HEADER_LEN = 7
);
    logic [N_REQ*PACKET_LEN-1:0]        packet_bits_i;
    logic [N_REQ*PACKET_HEADER_LEN-1:0] packet_len_i;
    logic [N_REQ-1:0]                   valid_i;
    logic [N_REQ-1:0]                   grant_o;
    logic [PACKET_LEN-1:0]              packet_bits_o;
    logic [PACKET_HEADER_LEN-1:0]       packet_len_o;
    logic                               valid_o;
    logic                               grant_i;

    modport master (
        input  packet_bits_i, packet_len_i, valid_i, grant_i,
        output grant_o, packet_bits_o, packet_len_o, valid_o
    );

    modport slave (
        output packet_bits_i, packet_len_i, valid_i, grant_i,
        input  grant_o, packet_bits_o, packet_len_o, valid_o
    );
endinterface

// File: rtl/trdb_packet_arbiter.sv
// Round-robin packet arbiter in front of the trace stream aligner; holds one source until granted.
// Define TRDB_ARB_STRICT_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module trdb_packet_arbiter #(
    parameter  int N_REQ             = 3,
    parameter  int PACKET_LEN        = 32,
    parameter  int PACKET_HEADER_LEN = 7,
    localparam int SEL_W             = $clog2(N_REQ)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    enable_i,
    input  logic                    flush_i,
    trdb_packet_arbiter_if.master   bus,
    output logic                    busy_o,
    output logic [SEL_W-1:0]        sel_o
);

    typedef enum logic {IDLE, LOCKED} state_e;

    state_e           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] scan_start;
    logic [SEL_W-1:0] win_idx;
    logic             win_found;
    logic             grant_hit;

    assign grant_hit = bus.grant_i & bus.valid_i[sel_q];

`ifdef TRDB_ARB_STRICT_PRIO_EN
    assign scan_start = '0;
`else
    logic [SEL_W-1:0] rr_q, rr_d;

    // Explicit wrap so non-power-of-2 source counts never land on an unused index.
    function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] idx);
        if (idx == SEL_W'(N_REQ - 1))
            return '0;
        return idx + 1'b1;
    endfunction

    assign scan_start = rr_q;

    always_comb begin
        rr_d = rr_q;
        if (state_q == LOCKED && !flush_i && grant_hit)
            rr_d = wrap_inc(sel_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            rr_q <= '0;
        else
            rr_q <= rr_d;
    end
`endif

    // First valid source at or above scan_start, wrapping modulo N_REQ.
    always_comb begin
        int               cand;
        logic [SEL_W-1:0] cand_idx;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = int'(scan_start) + k;
            if (cand >= N_REQ)
                cand = cand - N_REQ;
            cand_idx = cand[SEL_W-1:0];
            if (!win_found && bus.valid_i[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        unique case (state_q)
            IDLE: begin
                if (enable_i && !flush_i && win_found) begin
                    state_d = LOCKED;
                    sel_d   = win_idx;
                end
            end
            LOCKED: begin
                if (flush_i || grant_hit)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

    // Aligner-facing mux; the grant path stays combinational so the pop lands in the grant cycle.
    always_comb begin
        bus.packet_bits_o = '0;
        bus.packet_len_o  = '0;
        bus.valid_o       = 1'b0;
        bus.grant_o       = '0;
        if (state_q == LOCKED) begin
            bus.packet_bits_o    = bus.packet_bits_i[sel_q*PACKET_LEN +: PACKET_LEN];
            bus.packet_len_o     = bus.packet_len_i[sel_q*PACKET_HEADER_LEN +: PACKET_HEADER_LEN];
            bus.valid_o          = bus.valid_i[sel_q];
            bus.grant_o[sel_q]   = grant_hit & ~flush_i;
        end
    end

    assign busy_o = (state_q == LOCKED);
    assign sel_o  = sel_q;

endmodule
